mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges a simple core request interface to a multiplexed
// address/data memory bus (ALE / nOE / nME / RnW / ENB, nWait stretch).
// A transfer walks IDLE -> ADDR -> STROBE (MIN_WAIT+1 cycles minimum,
// stretched by nWait) -> END. All outputs are registered.
// Optional feature: define BUS_TIMEOUT_EN to abort a STROBE phase that
// nWait holds for TIMEOUT cycles (Err pulses together with Ack).
module mem_bus_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              Clock,
  input  logic              nReset,
  // core side
  input  logic              Req,
  input  logic              Write,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Ack,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              Err,
  // bus side
  output logic [DATA_W-1:0] Data_out,
  input  logic [DATA_W-1:0] Data_in,
  output logic              ALE,
  output logic              nOE,
  output logic              nME,
  output logic              RnW,
  output logic              ENB,
  input  logic              nWait
);

  localparam int unsigned WCNT_W = $clog2(MIN_WAIT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    STROBE = 2'd2,
    END    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ale_q, ale_d;
  logic                noe_q, noe_d;
  logic                nme_q, nme_d;
  logic                rnw_q, rnw_d;
  logic                enb_q, enb_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                wait_done_s;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_q, err_d;
`endif

  // The fixed wait phase is over once the saturating counter reaches MIN_WAIT.
  assign wait_done_s = (wcnt_q >= WCNT_W'(MIN_WAIT));

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    dout_d  = dout_q;
    ale_d   = 1'b0;
    noe_d   = 1'b1;
    nme_d   = 1'b1;
    rnw_d   = 1'b1;
    enb_d   = 1'b0;
    ack_d   = 1'b0;
    busy_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;
`endif

    // state transitions
    case (state_q)
      IDLE, END: begin
        if (Req) begin
          addr_d  = Addr;
          wdata_d = WData;
          write_d = Write;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        // counters clear so STROBE always starts from zero
        wcnt_d  = '0;
`ifdef BUS_TIMEOUT_EN
        tcnt_d  = '0;
`endif
        state_d = STROBE;
      end
      STROBE: begin
        if (wait_done_s) begin
          if (nWait) begin
            state_d = END;
            if (!write_q) begin
              rdata_d = Data_in;
            end else begin
              rdata_d = rdata_q;
            end
          end else begin
`ifdef BUS_TIMEOUT_EN
            tcnt_d = tcnt_q + TCNT_W'(1);
            if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
              state_d = END;
              err_d   = 1'b1;
            end else begin
              state_d = STROBE;
            end
`else
            state_d = STROBE;
`endif
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // outputs follow the state being entered, so they register with it
    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end
      ADDR: begin
        busy_d = 1'b1;
        ale_d  = 1'b1;
        nme_d  = 1'b0;
        enb_d  = 1'b1;
        rnw_d  = ~write_d;
        dout_d = addr_d;
      end
      STROBE: begin
        busy_d = 1'b1;
        nme_d  = 1'b0;
        rnw_d  = ~write_d;
        if (write_d) begin
          noe_d  = 1'b1;
          enb_d  = 1'b1;
          dout_d = wdata_d;
        end else begin
          noe_d  = 1'b0;
          enb_d  = 1'b0;
        end
      end
      END: begin
        // turnaround cycle: drivers off, Data_out keeps its last value
        busy_d = 1'b1;
        ack_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      dout_q  <= '0;
      ale_q   <= 1'b0;
      noe_q   <= 1'b1;
      nme_q   <= 1'b1;
      rnw_q   <= 1'b1;
      enb_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      ale_q   <= ale_d;
      noe_q   <= noe_d;
      nme_q   <= nme_d;
      rnw_q   <= rnw_d;
      enb_q   <= enb_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign Ack      = ack_q;
  assign RData    = rdata_q;
  assign Busy     = busy_q;
  assign Data_out = dout_q;
  assign ALE      = ale_q;
  assign nOE      = noe_q;
  assign nME      = nme_q;
  assign RnW      = rnw_q;
  assign ENB      = enb_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: one instance with MIN_WAIT=0 and one
// with MIN_WAIT=2; a scoreboard queue per instance holds the expected
// RData/Err of every accepted transfer and is drained on each Ack.
module tb_mem_bus_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [15:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req2 = 1'b0;
  logic        write_i = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000, data_in = 16'h0000;
  logic        nwait = 1'b1;

  logic        ack0, busy0, err0, ale0, noe0, nme0, rnw0, enb0;
  logic [15:0] rdata0, dout0;
  logic        ack2, busy2, err2, ale2, noe2, nme2, rnw2, enb2;
  logic [15:0] rdata2, dout2;

  exp_t q0[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.DATA_W(16), .MIN_WAIT(0), .TIMEOUT(TIMEOUT)) dut0 (
    .Clock(clk), .nReset(rst_n), .Req(req0), .Write(write_i), .Addr(addr),
    .WData(wdata), .Ack(ack0), .RData(rdata0), .Busy(busy0), .Err(err0),
    .Data_out(dout0), .Data_in(data_in), .ALE(ale0), .nOE(noe0), .nME(nme0),
    .RnW(rnw0), .ENB(enb0), .nWait(nwait)
  );

  mem_bus_ctrl #(.DATA_W(16), .MIN_WAIT(2), .TIMEOUT(TIMEOUT)) dut2 (
    .Clock(clk), .nReset(rst_n), .Req(req2), .Write(write_i), .Addr(addr),
    .WData(wdata), .Ack(ack2), .RData(rdata2), .Busy(busy2), .Err(err2),
    .Data_out(dout2), .Data_in(data_in), .ALE(ale2), .nOE(noe2), .nME(nme2),
    .RnW(rnw2), .ENB(enb2), .nWait(nwait)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every Ack pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (ack0) begin
      if (q0.size() == 0) begin
        chk("sb0_unexpected_ack", ack0, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("sb0_rdata", rdata0, e.rd);
        chk("sb0_err", err0, e.err);
      end
    end else if (err0) begin
      chk("sb0_err_without_ack", err0, 1'b0);
    end
    if (ack2) begin
      if (q2.size() == 0) begin
        chk("sb2_unexpected_ack", ack2, 1'b0);
      end else begin
        e = q2.pop_front();
        chk("sb2_rdata", rdata2, e.rd);
        chk("sb2_err", err2, e.err);
      end
    end else if (err2) begin
      chk("sb2_err_without_ack", err2, 1'b0);
    end
  end

  // One transfer, started from a negedge. nWait is low for the first 'low'
  // STROBE cycles. Checks bus phases, STROBE length and Ack latency.
  task automatic xfer(input bit sel2, input bit wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] din,
                      input int low, input int exp_strobe,
                      input logic [15:0] exp_rd, input bit exp_err);
    int cyc, strb, ales;
    bit got_ack;
    logic s_ale, s_noe, s_nme, s_rnw, s_enb, s_ack, s_busy;
    logic [15:0] s_dout;
    write_i = wr; addr = a; wdata = wd; data_in = din;
    nwait = (low == 0);
    if (sel2) begin
      req2 = 1'b1;
      q2.push_back('{rd: exp_rd, err: exp_err});
    end else begin
      req0 = 1'b1;
      q0.push_back('{rd: exp_rd, err: exp_err});
    end
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    cyc = 0; strb = 0; ales = 0; got_ack = 1'b0;
    while (!got_ack && cyc < 300) begin
      @(negedge clk);
      cyc++;
      s_ale  = sel2 ? ale2  : ale0;
      s_noe  = sel2 ? noe2  : noe0;
      s_nme  = sel2 ? nme2  : nme0;
      s_rnw  = sel2 ? rnw2  : rnw0;
      s_enb  = sel2 ? enb2  : enb0;
      s_ack  = sel2 ? ack2  : ack0;
      s_busy = sel2 ? busy2 : busy0;
      s_dout = sel2 ? dout2 : dout0;
      chk("busy_during_xfer", s_busy, 1'b1);
      if (s_ale) begin
        ales++;
        chk("addr_dout", s_dout, a);
        chk("addr_nme", s_nme, 1'b0);
        chk("addr_enb", s_enb, 1'b1);
        chk("addr_rnw", s_rnw, !wr);
      end else if (!s_nme) begin
        strb++;
        chk("strobe_rnw", s_rnw, !wr);
        chk("strobe_noe", s_noe, wr);
        chk("strobe_enb", s_enb, wr);
        if (wr) chk("strobe_wdata", s_dout, wd);
        nwait = (strb > low);
      end
      if (s_ack) begin
        got_ack = 1'b1;
        chk("end_ale", s_ale, 1'b0);
        chk("end_noe", s_noe, 1'b1);
        chk("end_nme", s_nme, 1'b1);
        chk("end_rnw", s_rnw, 1'b1);
        chk("end_enb", s_enb, 1'b0);
        chk("end_dout_hold", s_dout, wr ? wd : a);
      end
    end
    chk("ack_seen", got_ack, 1'b1);
    chk("ale_cycles", ales, 1);
    chk("strobe_cycles", strb, exp_strobe);
    chk("ack_latency", cyc, exp_strobe + 2);
    nwait = 1'b1;
    @(negedge clk);
    chk("ack_single_pulse", sel2 ? ack2 : ack0, 1'b0);
    chk("idle_busy", sel2 ? busy2 : busy0, 1'b0);
  endtask

  initial begin
    int cnt, bad, acks, busy_n, ale_n;
    logic [15:0] tbl [3];
    tbl[0] = 16'h1111; tbl[1] = 16'h2222; tbl[2] = 16'h3333;

    // reset state
    #12;
    chk("rst0_ctrl", {ale0, noe0, nme0, rnw0, enb0, ack0, err0, busy0}, 8'b0111_0000);
    chk("rst0_dout", dout0, 16'h0000);
    chk("rst0_rdata", rdata0, 16'h0000);
    chk("rst2_ctrl", {ale2, noe2, nme2, rnw2, enb2, ack2, err2, busy2}, 8'b0111_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait read: Ack on cycle 3, RData = BEEF
    xfer(1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1, 16'hBEEF, 1'b0);
    // MIN_WAIT=2: read, write (RData unchanged), read with extra waits
    xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h5A5A, 0, 3, 16'h5A5A, 1'b0);
    xfer(1'b1, 1'b1, 16'h0040, 16'h00FF, 16'hDEAD, 0, 3, 16'h5A5A, 1'b0);
    xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1357, 3, 4, 16'h1357, 1'b0);
    // nWait stretch: 4 low cycles -> STROBE lasts 5
    xfer(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h2468, 4, 5, 16'h2468, 1'b0);

`ifdef BUS_TIMEOUT_EN
    // abort after TIMEOUT low cycles, RData keeps previous read value
    xfer(1'b0, 1'b0, 16'h0400, 16'h0000, 16'h9999, 1000, TIMEOUT, 16'h2468, 1'b1);
`else
    // no timeout: STROBE holds for 120 cycles, then completes on nWait=1
    write_i = 1'b0; addr = 16'h0400; data_in = 16'hCAFE; nwait = 1'b0;
    req0 = 1'b1;
    q0.push_back('{rd: 16'hCAFE, err: 1'b0});
    @(posedge clk); #1; req0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 121; i++) begin
      @(negedge clk);
      if (!nme0 && !ale0 && !ack0) cnt++;
    end
    chk("no_timeout_hold", cnt, 120);
    nwait = 1'b1;
    @(negedge clk);
    chk("no_timeout_release_ack", ack0, 1'b1);
    @(negedge clk);
`endif

    // back-to-back: three reads with Req held high
    write_i = 1'b0; addr = 16'h0100; data_in = tbl[0]; nwait = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back('{rd: tbl[i], err: 1'b0});
    req0 = 1'b1;
    @(posedge clk); #1;
    bad = 0; acks = 0; busy_n = 0; ale_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ale0) begin
        data_in = tbl[ale_n];
        ale_n++;
        if (ale_n == 3) req0 = 1'b0;
      end
      if (ack0 !== ((k % 3) == 0 && k <= 9)) bad++;
      if (ack0) acks++;
      if (busy0 && k <= 9) busy_n++;
      if (k == 10) chk("b2b_idle_after", busy0, 1'b0);
    end
    chk("b2b_ack_pattern_errors", bad, 0);
    chk("b2b_ack_count", acks, 3);
    chk("b2b_busy_cycles", busy_n, 9);

    // reset in the middle of STROBE
    write_i = 1'b0; addr = 16'h0AAA; data_in = 16'h7777; nwait = 1'b0;
    req0 = 1'b1;
    @(posedge clk); #1; req0 = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_in_strobe", nme0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {ale0, noe0, nme0, rnw0, enb0, ack0, err0, busy0}, 8'b0111_0000);
    chk("mid_rst_dout", dout0, 16'h0000);
    chk("mid_rst_rdata", rdata0, 16'h0000);
    @(negedge clk);
    chk("mid_rst_no_ack", ack0, 1'b0);
    rst_n = 1'b1; nwait = 1'b1;
    xfer(1'b0, 1'b0, 16'h0BBB, 16'h0000, 16'h4242, 0, 1, 16'h4242, 1'b0);

    chk("sb0_drained", q0.size(), 0);
    chk("sb2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
